// File: rtl/sba_arbiter_if.sv
// sba_arbiter_if
//   One SBA simple-bus link: request fields flow from master to slave,
//   response fields flow back.
//   stb    request strobe, held until ack
//   we     byte write enables (0 = read)
//   addr   byte address
//   dat_w  write data
//   dat_r  read data
//   ack    transfer done
//   err    timeout termination; qualifies ack
// modport master : the requester side of a link. err is not part of this
//                  view because the downstream slave has no error return.
// modport slave  : the responder side of a link.
interface sba_arbiter_if;
  logic        stb;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (output stb, we, addr, dat_w, input dat_r, ack);
  modport slave  (input stb, we, addr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/sba_arbiter.sv
// sba_arbiter
//   Two-master to one-slave round-robin arbiter for the SBA simple bus.
//   A grant is held until the slave acks; a per-transaction watchdog
//   terminates hung accesses with an error ack.
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   m0          master 0 (CPU) link, slave view
//   m1          master 1 (boot loader / DMA) link, slave view
//   s           link towards the address decoder / slave mux, master view
//   o_timeout   one-cycle pulse on every watchdog termination
//   o_err_addr  address of the most recent timed-out access (sticky)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | bus free; arbitrate on sampled stb, slave ack ignored
// ST_BUSY0 | master 0 owns the slave until ack or timeout
// ST_BUSY1 | master 1 owns the slave until ack or timeout
module sba_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sba_arbiter_if.slave  m0,
  sba_arbiter_if.slave  m1,
  sba_arbiter_if.master s,
  output logic          o_timeout,
  output logic [31:0]   o_err_addr
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             sel1;
  logic             tc;
  logic             done;

  assign busy = (state == ST_BUSY0) || (state == ST_BUSY1);
  assign sel1 = (state == ST_BUSY1);

  // A real ack on the last allowed cycle wins over the watchdog.
  assign tc   = busy && (cnt == CNT_LAST) && !s.ack;
  assign done = busy && (s.ack || tc);

  assign o_timeout = tc;

  // Request path: forward the owner's fields, quiet bus otherwise.
  always_comb begin
    s.stb   = busy;
    s.we    = '0;
    s.addr  = '0;
    s.dat_w = '0;
    if (busy) begin
      if (sel1) begin
        s.we    = m1.we;
        s.addr  = m1.addr;
        s.dat_w = m1.dat_w;
      end else begin
        s.we    = m0.we;
        s.addr  = m0.addr;
        s.dat_w = m0.dat_w;
      end
    end
  end

  // Response path: only the owner ever sees ack/err/data. Gating on state
  // (not on s.ack alone) keeps a stale ack in IDLE away from both masters.
  always_comb begin
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_r = '0;
    if (state == ST_BUSY0) begin
      m0.ack   = s.ack || tc;
      m0.err   = tc;
      m0.dat_r = tc ? ERR_DATA : s.dat_r;
    end else if (state == ST_BUSY1) begin
      m1.ack   = s.ack || tc;
      m1.err   = tc;
      m1.dat_r = tc ? ERR_DATA : s.dat_r;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m0.stb && m1.stb) begin
          state_nxt = last_grant ? ST_BUSY0 : ST_BUSY1;
        end else if (m0.stb) begin
          state_nxt = ST_BUSY0;
        end else if (m1.stb) begin
          state_nxt = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      o_err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        // Clearing every IDLE cycle means each grant starts from zero.
        cnt <= '0;
        if (state_nxt == ST_BUSY0) begin
          last_grant <= 1'b0;
        end else if (state_nxt == ST_BUSY1) begin
          last_grant <= 1'b1;
        end
      end else if (!s.ack && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end
      if (tc) begin
        o_err_addr <= s.addr;
      end
    end
  end

endmodule

// File: tb/tb_sba_arbiter.sv
module tb_sba_arbiter;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_timeout;
  logic [31:0] o_err_addr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_err_addr;
  int          m_last;

  sba_arbiter_if m0_if ();
  sba_arbiter_if m1_if ();
  sba_arbiter_if s_if ();

  sba_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (ERR_D)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .o_timeout (o_timeout),
    .o_err_addr(o_err_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input int m, input logic stb, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] dat);
    if (m == 0) begin
      m0_if.stb = stb; m0_if.we = we; m0_if.addr = addr; m0_if.dat_w = dat;
    end else begin
      m1_if.stb = stb; m1_if.we = we; m1_if.addr = addr; m1_if.dat_w = dat;
    end
  endtask

  function automatic logic [31:0] resp_vec();
    return 32'({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, o_timeout});
  endfunction

  // Called in an IDLE cycle with requests already presented. The slave
  // acks in BUSY cycle ack_cyc (0-based); anything past TO-1 means the
  // watchdog must end it. Returns in the following IDLE cycle.
  task automatic txn(input int exp_m, input int ack_cyc, input logic [31:0] rdata,
                     input bit keep, input bit stale, input string tag);
    logic [31:0] e_addr, e_dat, e_we;
    bit fin, to;
    e_addr = (exp_m == 1) ? m1_if.addr  : m0_if.addr;
    e_dat  = (exp_m == 1) ? m1_if.dat_w : m0_if.dat_w;
    e_we   = 32'((exp_m == 1) ? m1_if.we : m0_if.we);
    #2;
    chk({tag, "/idle_stb"}, 32'(s_if.stb), 32'd0);
    chk({tag, "/idle_resp"}, resp_vec(), 32'd0);
    fin = 1'b0;
    for (int k = 0; k < int'(TO) && !fin; k++) begin
      @(posedge i_clk); #1;
      s_if.ack   = (k == ack_cyc);
      s_if.dat_r = rdata;
      #2;
      to  = (k == int'(TO) - 1) && (k != ack_cyc);
      fin = (k == ack_cyc) || to;
      chk({tag, "/stb"},   32'(s_if.stb), 32'd1);
      chk({tag, "/addr"},  s_if.addr,     e_addr);
      chk({tag, "/we"},    32'(s_if.we),  e_we);
      chk({tag, "/dat_w"}, s_if.dat_w,    e_dat);
      if (exp_m == 0) begin
        chk({tag, "/resp"},    resp_vec(),  32'({fin, to, 1'b0, 1'b0, to}));
        chk({tag, "/dat_r"},   m0_if.dat_r, to ? ERR_D : rdata);
        chk({tag, "/other_r"}, m1_if.dat_r, 32'd0);
      end else begin
        chk({tag, "/resp"},    resp_vec(),  32'({1'b0, 1'b0, fin, to, to}));
        chk({tag, "/dat_r"},   m1_if.dat_r, to ? ERR_D : rdata);
        chk({tag, "/other_r"}, m0_if.dat_r, 32'd0);
      end
      chk({tag, "/err_addr"}, o_err_addr, exp_err_addr);
      if (to) exp_err_addr = e_addr;
    end
    @(posedge i_clk); #1;
    s_if.ack = stale;
    if (!keep) begin
      m0_if.stb = 1'b0;
      m1_if.stb = 1'b0;
    end
    #2;
    chk({tag, "/end_stb"},  32'(s_if.stb), 32'd0);
    chk({tag, "/end_resp"}, resp_vec(),    32'd0);
    chk({tag, "/end_eadr"}, o_err_addr,    exp_err_addr);
    m_last = exp_m;
    #0;
  endtask

  initial begin
    int r, exp_m;
    i_rst = 1'b1;
    drive_m(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m(1, 1'b0, 4'h0, 32'h0, 32'h0);
    s_if.ack = 1'b0; s_if.dat_r = 32'h0; s_if.err = 1'b0;
    exp_err_addr = 32'h0;
    m_last = 1;

    #3;
    chk("rst/stb",      32'(s_if.stb), 32'd0);
    chk("rst/resp",     resp_vec(),    32'd0);
    chk("rst/err_addr", o_err_addr,    32'd0);
    chk("rst/m0_dat_r", m0_if.dat_r,   32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Both masters requesting continuously from reset: 0,1,0,1.
    drive_m(0, 1'b1, 4'h0, 32'h1000_0000, 32'h0);
    drive_m(1, 1'b1, 4'h0, 32'h2000_0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      txn(i % 2, 1, 32'hC0DE_0000 + 32'(i), i < 3, 1'b0, "rr");
    end

    drive_m(0, 1'b1, 4'b0000, 32'h1000_0004, 32'h0);
    txn(0, 1, 32'h1234_5678, 1'b0, 1'b0, "m0_rd");

    // Stale ack held high through the IDLE cycles after the write.
    drive_m(1, 1'b1, 4'b0101, 32'h2000_0008, 32'hAABB_CCDD);
    txn(1, 1, 32'h0, 1'b0, 1'b1, "m1_wr");
    @(posedge i_clk); #3;
    chk("stale/resp", resp_vec(), 32'd0);
    chk("stale/stb",  32'(s_if.stb), 32'd0);
    s_if.ack = 1'b0;

    drive_m(0, 1'b1, 4'h0, 32'h3000_0010, 32'h0);
    txn(0, 99, 32'h5555_AAAA, 1'b0, 1'b0, "tmo");
    chk("tmo/err_addr", o_err_addr, 32'h3000_0010);

    drive_m(0, 1'b1, 4'hF, 32'h3000_0020, 32'h0BAD_F00D);
    txn(0, 3, 32'h7777_0001, 1'b0, 1'b0, "ack_last");

    // Random traffic against the round-robin / watchdog rules.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 3));
      drive_m(0, r[0], 4'($urandom), $urandom, $urandom);
      drive_m(1, r[1], 4'($urandom), $urandom, $urandom);
      if (r == 0) begin
        @(posedge i_clk); #3;
        chk("rnd/no_req_stb", 32'(s_if.stb), 32'd0);
        #0;
      end else begin
        if (r == 3) exp_m = (m_last == 1) ? 0 : 1;
        else        exp_m = (r == 1) ? 0 : 1;
        txn(exp_m, int'($urandom_range(0, 5)), $urandom, 1'b0, 1'($urandom), "rnd");
      end
    end

    // Asynchronous reset in the middle of a BUSY1 transfer.
    s_if.ack = 1'b0;
    drive_m(1, 1'b1, 4'h3, 32'h4000_0000, 32'h1111_2222);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    s_if.ack = 1'b1;
    #2;
    chk("arst/pre_ack", resp_vec(), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    #1;
    i_rst = 1'b1;
    #1;
    chk("arst/stb",      32'(s_if.stb), 32'd0);
    chk("arst/resp",     resp_vec(),    32'd0);
    chk("arst/err_addr", o_err_addr,    32'd0);
    exp_err_addr = 32'h0;
    m_last = 1;
    @(posedge i_clk); #1;
    s_if.ack = 1'b0;
    i_rst = 1'b0;
    drive_m(0, 1'b1, 4'h0, 32'h5000_0000, 32'h0);
    drive_m(1, 1'b1, 4'h0, 32'h6000_0000, 32'h0);
    txn(0, 0, 32'h9999_0000, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
